// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, phase encoding, ALU classes and
// the packed control word latched once per instruction.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_PASS  = 2'b11
  } aluop_t;

  typedef struct packed {
    logic   branch;
    logic   jump;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    logic   regwrite;
    aluop_t aluop;
  } ctrl_word_t;

  // Loads and stores are the only classes that visit the MEM phase.
  function automatic logic cw_needs_mem(input ctrl_word_t cw);
    return cw.memread | cw.memwrite;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle control unit (master) and the datapath
// (slave): instruction/memory status in, phase, strobes and control word out.
interface mc_control_fsm_if #(
  parameter int ALUOP_W = 2
);
  logic [6:0]         opcode;
  logic               mem_ready;
  logic [2:0]         state;
  logic               irwrite;
  logic               pcwrite;
  logic               branch;
  logic               jump;
  logic               memread;
  logic               memwrite;
  logic               memtoreg;
  logic               alusrc;
  logic               regwrite;
  logic [ALUOP_W-1:0] aluop;
  logic               illegal;

  modport master (
    input  opcode, mem_ready,
    output state, irwrite, pcwrite, branch, jump, memread, memwrite,
           memtoreg, alusrc, regwrite, aluop, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  state, irwrite, pcwrite, branch, jump, memread, memwrite,
           memtoreg, alusrc, regwrite, aluop, illegal
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode decoder: produces the control word for one instruction
// and flags opcodes this configuration cannot execute.
module mc_opcode_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit EXT_OPS = 1'b0
) (
  input  logic [6:0] opcode,
  output ctrl_word_t cw,
  output logic       illegal
);

  always_comb begin
    cw      = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cw.regwrite = 1'b1;
        cw.aluop    = ALU_FUNCT;
      end
      OP_LOAD: begin
        cw.alusrc   = 1'b1;
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
        cw.memread  = 1'b1;
        cw.aluop    = ALU_ADD;
      end
      OP_STORE: begin
        cw.alusrc   = 1'b1;
        cw.memwrite = 1'b1;
        cw.aluop    = ALU_ADD;
      end
      OP_BRANCH: begin
        cw.branch = 1'b1;
        cw.aluop  = ALU_SUB;
      end
      OP_ADDI: begin
        cw.alusrc   = 1'b1;
        cw.regwrite = 1'b1;
        cw.aluop    = ALU_ADD;
      end
      OP_JAL: begin
        if (EXT_OPS) begin
          cw.jump     = 1'b1;
          cw.regwrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EXT_OPS) begin
          cw.jump     = 1'b1;
          cw.regwrite = 1'b1;
          cw.alusrc   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        if (EXT_OPS) begin
          cw.alusrc   = 1'b1;
          cw.regwrite = 1'b1;
          cw.aluop    = ALU_PASS;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, latches
// the decoded control word in DECODE and holds it until the next FETCH.
module mc_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b0,
  parameter int ALUOP_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus
);

  state_t     state_q, state_d;
  ctrl_word_t cw_q, cw_d, dec_cw;
  logic       dec_illegal;
  logic       ready;
  logic       irwrite_c, pcwrite_c, illegal_c;

  mc_opcode_decode #(.EXT_OPS(EXT_OPS)) u_dec (
    .opcode  (bus.opcode),
    .cw      (dec_cw),
    .illegal (dec_illegal)
  );

  assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
    end
  end

  // Every path that lands in FETCH also clears the control word on that edge.
  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    irwrite_c = 1'b0;
    pcwrite_c = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        cw_d = '0;
        if (ready) begin
          irwrite_c = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_c = 1'b1;
          pcwrite_c = 1'b1;
          cw_d      = '0;
          state_d   = ST_FETCH;
        end else begin
          cw_d    = dec_cw;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cw_needs_mem(cw_q)) begin
          state_d = ST_MEM;
        end else if (cw_q.branch) begin
          pcwrite_c = 1'b1;
          cw_d      = '0;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (ready) begin
          if (cw_q.memread) begin
            state_d = ST_WB;
          end else begin
            pcwrite_c = 1'b1;
            cw_d      = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        pcwrite_c = 1'b1;
        cw_d      = '0;
        state_d   = ST_FETCH;
      end
      default: begin
        cw_d    = '0;
        state_d = ST_FETCH;
      end
    endcase
  end

  // Strobes are masked while reset is held so the datapath sees a quiet bus.
  assign bus.state    = state_q;
  assign bus.irwrite  = irwrite_c & ~reset;
  assign bus.pcwrite  = pcwrite_c & ~reset;
  assign bus.illegal  = illegal_c & ~reset;
  assign bus.branch   = cw_q.branch;
  assign bus.jump     = cw_q.jump;
  assign bus.memread  = cw_q.memread;
  assign bus.memwrite = cw_q.memwrite;
  assign bus.memtoreg = cw_q.memtoreg;
  assign bus.alusrc   = cw_q.alusrc;
  assign bus.regwrite = cw_q.regwrite;
  assign bus.aluop    = ALUOP_W'(cw_q.aluop);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two configurations (waiting/EXT vs single-cycle/base)
// driven by scenario tasks and random instructions against a phase-list model.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  mc_control_fsm_if #(.ALUOP_W(2)) ifa ();
  mc_control_fsm_if #(.ALUOP_W(3)) ifb ();

  mc_control_fsm #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1), .ALUOP_W(2)) duta (
    .clk(clk), .reset(rst_a), .bus(ifa));
  mc_control_fsm #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0), .ALUOP_W(3)) dutb (
    .clk(clk), .reset(rst_b), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  localparam int MAXC = 64;
  localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, SW = 7'b0100011,
                         BR = 7'b1100011, ADDI = 7'b0010011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  // expected trace; cw bits = {branch,jump,memread,memwrite,memtoreg,alusrc,regwrite,aluop[1:0]}
  int         exp_n;
  logic [2:0] exp_st [MAXC];
  logic [2:0] exp_sb [MAXC];   // {irwrite,pcwrite,illegal}
  logic [8:0] exp_cw [MAXC];
  logic       exp_rdy[MAXC];

  int         tr_n;
  logic [2:0] tr_st [MAXC];
  logic [2:0] tr_sb [MAXC];
  logic [8:0] tr_cw [MAXC];
  logic       tr_hi [MAXC];
  logic [2:0] tr_post;

  // Reference decode table, returns {legal, cw}.
  function automatic logic [9:0] ref_decode(input logic [6:0] op, input bit ext);
    case (op)
      R:           return {1'b1, 9'b0000001_10};
      LD:          return {1'b1, 9'b0010111_00};
      SW:          return {1'b1, 9'b0001010_00};
      BR:          return {1'b1, 9'b1000000_01};
      ADDI:        return {1'b1, 9'b0000011_00};
      JAL:         return ext ? {1'b1, 9'b0100001_00} : 10'b0;
      JALR:        return ext ? {1'b1, 9'b0100011_00} : 10'b0;
      LUI, AUIPC:  return ext ? {1'b1, 9'b0000011_11} : 10'b0;
      default:     return 10'b0;
    endcase
  endfunction

  task automatic push(input logic [2:0] s, input logic [2:0] sb, input logic [8:0] cw, input logic r);
    exp_st[exp_n] = s; exp_sb[exp_n] = sb; exp_cw[exp_n] = cw; exp_rdy[exp_n] = r;
    exp_n++;
  endtask

  // Builds the per-cycle expectation from the phase list of the instruction class.
  task automatic build_exp(input logic [6:0] op, input bit ext, input bit mw, input int fs, input int ms);
    logic [9:0] d;
    logic [8:0] cw;
    bit ld, st, br;
    d = ref_decode(op, ext);
    cw = d[8:0];
    ld = (op == LD); st = (op == SW); br = (op == BR);
    exp_n = 0;
    if (mw) begin
      for (int i = 0; i < fs; i++) push(3'd0, 3'b000, 9'd0, 1'b0);
      push(3'd0, 3'b100, 9'd0, 1'b1);
    end else push(3'd0, 3'b100, 9'd0, 1'($urandom));
    if (!d[9]) begin
      push(3'd1, 3'b011, 9'd0, 1'($urandom));
      return;
    end
    push(3'd1, 3'b000, 9'd0, 1'($urandom));
    push(3'd2, br ? 3'b010 : 3'b000, cw, 1'($urandom));
    if (ld || st) begin
      if (mw) begin
        for (int i = 0; i < ms; i++) push(3'd3, 3'b000, cw, 1'b0);
        push(3'd3, st ? 3'b010 : 3'b000, cw, 1'b1);
      end else push(3'd3, st ? 3'b010 : 3'b000, cw, 1'($urandom));
    end
    if (!br && !st) push(3'd4, 3'b010, cw, 1'($urandom));
  endtask

  function automatic logic [14:0] snap(input bit b);
    if (b) return {ifb.state, ifb.irwrite, ifb.pcwrite, ifb.illegal, ifb.branch, ifb.jump,
                   ifb.memread, ifb.memwrite, ifb.memtoreg, ifb.alusrc, ifb.regwrite, ifb.aluop[1:0]};
    return {ifa.state, ifa.irwrite, ifa.pcwrite, ifa.illegal, ifa.branch, ifa.jump,
            ifa.memread, ifa.memwrite, ifa.memtoreg, ifa.alusrc, ifa.regwrite, ifa.aluop};
  endfunction

  // Runs one instruction on DUT b (0 = wait/EXT, 1 = single-cycle/base), recording
  // one sample per cycle; the idle DUT is parked in reset.
  task automatic run_instr(input bit b, input logic [6:0] op, input int fs, input int ms);
    logic [14:0] s;
    build_exp(op, !b, !b, fs, ms);
    rst_a = b; rst_b = !b;
    tr_n = exp_n;
    for (int i = 0; i < exp_n; i++) begin
      if (b) begin
        ifb.opcode = (exp_st[i] == 3'd0) ? 7'($urandom) : op;
        ifb.mem_ready = exp_rdy[i];
      end else begin
        ifa.opcode = (exp_st[i] == 3'd0) ? 7'($urandom) : op;
        ifa.mem_ready = exp_rdy[i];
      end
      @(negedge clk);
      s = snap(b);
      tr_st[i] = s[14:12]; tr_sb[i] = s[11:9]; tr_cw[i] = s[8:0];
      tr_hi[i] = b ? ifb.aluop[2] : 1'b0;
      @(posedge clk); #1;
    end
    tr_post = b ? ifb.state : ifa.state;
  endtask

  task automatic test_reset;
    logic [14:0] s;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.mem_ready = 1'b1; ifb.mem_ready = 1'b1;
    ifa.opcode = 7'h7f;   ifb.opcode = 7'h7f;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      s = snap(b[0]);
      n_cmp++;
      if (s !== 15'd0) begin
        n_bad++; $display("FAIL reset_outputs dut%0d: got %h want 0", b, s);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_nowait;
    logic [2:0] seq [4];
    seq = '{3'd0, 3'd1, 3'd2, 3'd4};
    run_instr(1'b1, R, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tr_st[i] !== seq[i] || tr_sb[i][1] !== (i == 3)) begin
        n_bad++; $display("FAIL rtype_seq cyc%0d: got st=%0d pcw=%b want st=%0d pcw=%b", i, tr_st[i], tr_sb[i][1], seq[i], i == 3);
      end
    end
    for (int i = 2; i < 4; i++) begin
      n_cmp++;
      if (tr_cw[i][2] !== 1'b1 || tr_cw[i][1:0] !== 2'b10 || tr_hi[i] !== 1'b0) begin
        n_bad++; $display("FAIL rtype_cw cyc%0d: got %b hi=%b want regwrite aluop=10", i, tr_cw[i], tr_hi[i]);
      end
    end
    n_cmp++;
    if (tr_post !== 3'd0) begin n_bad++; $display("FAIL rtype_end: got %0d want 0", tr_post); end
  endtask

  task automatic test_load_stall;
    int lat;
    run_instr(1'b0, LD, 2, 3);
    lat = -1;
    for (int k = 1; k < tr_n; k++)
      if (lat < 0 && tr_st[k] == 3'd0 && tr_st[k-1] != 3'd0) lat = k;
    if (lat < 0 && tr_post == 3'd0) lat = tr_n;
    n_cmp++;
    if (lat !== 10) begin n_bad++; $display("FAIL load_latency: got %0d want 10", lat); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tr_sb[i][2] !== (i == 2)) begin
        n_bad++; $display("FAIL load_irwrite cyc%0d: got %b want %b", i, tr_sb[i][2], i == 2);
      end
    end
    for (int i = 4; i < 10; i++) begin
      n_cmp++;
      if (tr_cw[i][6] !== 1'b1 || tr_cw[i][4] !== 1'b1) begin
        n_bad++; $display("FAIL load_hold cyc%0d: got cw=%b want memread+memtoreg", i, tr_cw[i]);
      end
    end
    for (int i = 5; i < 9; i++) begin
      n_cmp++;
      if (tr_st[i] !== 3'd3) begin n_bad++; $display("FAIL load_mem_stall cyc%0d: got %0d want 3", i, tr_st[i]); end
    end
  endtask

  task automatic test_store;
    int ms;
    ms = $urandom_range(1, 3);
    run_instr(1'b0, SW, 0, ms);
    n_cmp++;
    if (tr_st[2] !== 3'd2 || tr_cw[2][5] !== 1'b1 || tr_cw[2][2] !== 1'b0) begin
      n_bad++; $display("FAIL store_exec: got st=%0d cw=%b want st=2 memwrite=1 regwrite=0", tr_st[2], tr_cw[2]);
    end
    for (int i = 3; i < tr_n; i++) begin
      n_cmp++;
      if (tr_st[i] !== 3'd3 || tr_sb[i][1] !== (i == tr_n - 1)) begin
        n_bad++; $display("FAIL store_mem cyc%0d: got st=%0d pcw=%b want st=3 pcw=%b", i, tr_st[i], tr_sb[i][1], i == tr_n - 1);
      end
    end
    n_cmp++;
    if (tr_post !== 3'd0) begin n_bad++; $display("FAIL store_end: got %0d want 0", tr_post); end
  endtask

  task automatic test_branch;
    run_instr(1'b1, BR, 0, 0);
    n_cmp++;
    if (tr_st[2] !== 3'd2 || tr_cw[2] !== 9'b1000000_01 || tr_sb[2] !== 3'b010) begin
      n_bad++; $display("FAIL branch_exec: got st=%0d cw=%b sb=%b want 2/100000001/010", tr_st[2], tr_cw[2], tr_sb[2]);
    end
    n_cmp++;
    if (tr_post !== 3'd0) begin n_bad++; $display("FAIL branch_end: got %0d want 0", tr_post); end
  endtask

  task automatic test_ext_jal;
    run_instr(1'b1, JAL, 0, 0);
    n_cmp++;
    if (tr_st[1] !== 3'd1 || tr_sb[1] !== 3'b011 || tr_cw[1] !== 9'd0 || tr_post !== 3'd0) begin
      n_bad++; $display("FAIL jal_illegal: got st=%0d sb=%b cw=%b post=%0d want 1/011/0/0", tr_st[1], tr_sb[1], tr_cw[1], tr_post);
    end
    run_instr(1'b0, JAL, 0, 0);
    for (int i = 2; i < 4; i++) begin
      n_cmp++;
      if (tr_cw[i] !== 9'b0100001_00) begin
        n_bad++; $display("FAIL jal_ext_cw cyc%0d: got %b want 010000100", i, tr_cw[i]);
      end
    end
    n_cmp++;
    if (tr_st[3] !== 3'd4 || tr_sb[3] !== 3'b010 || tr_post !== 3'd0) begin
      n_bad++; $display("FAIL jal_ext_seq: got st=%0d sb=%b post=%0d want 4/010/0", tr_st[3], tr_sb[3], tr_post);
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [14:0] s;
    rst_a = 1'b0; rst_b = 1'b1;
    ifa.opcode = LD; ifa.mem_ready = 1'b1;
    @(posedge clk); #1;          // DECODE
    ifa.mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end   // EXEC, MEM, MEM (stalled)
    n_cmp++;
    if (ifa.state !== 3'd3 || ifa.memread !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_setup: got st=%0d memread=%b want 3/1", ifa.state, ifa.memread);
    end
    rst_a = 1'b1; ifa.mem_ready = 1'b1;
    #1;
    s = snap(1'b0);
    n_cmp++;
    if (s !== 15'd0) begin n_bad++; $display("FAIL rst_mid_async: got %h want 0", s); end
    @(posedge clk); #1;
    s = snap(1'b0);
    n_cmp++;
    if (s !== 15'd0) begin n_bad++; $display("FAIL rst_mid_held: got %h want 0", s); end
    rst_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifa.state !== 3'd0 || ifa.irwrite !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_fetch: got st=%0d irw=%b want 0/1", ifa.state, ifa.irwrite);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ifa.state !== 3'd1) begin n_bad++; $display("FAIL rst_restart: got %0d want 1", ifa.state); end
    rst_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [6:0] ops [9];
    logic [6:0] op;
    bit b;
    int idx;
    ops = '{R, LD, SW, BR, ADDI, JAL, JALR, LUI, AUIPC};
    for (int n = 0; n < 40; n++) begin
      b = 1'($urandom);
      idx = $urandom_range(0, 10);
      op = (idx < 9) ? ops[idx] : 7'($urandom);
      run_instr(b, op, $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < tr_n; i++) begin
        n_cmp++;
        if (tr_st[i] !== exp_st[i] || tr_sb[i] !== exp_sb[i] || tr_cw[i] !== exp_cw[i] || tr_hi[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL rand op=%b dut%0d cyc%0d: got st=%0d sb=%b cw=%b hi=%b want st=%0d sb=%b cw=%b",
                   op, b, i, tr_st[i], tr_sb[i], tr_cw[i], tr_hi[i], exp_st[i], exp_sb[i], exp_cw[i]);
        end
      end
      n_cmp++;
      if (tr_post !== 3'd0) begin n_bad++; $display("FAIL rand_end op=%b dut%0d: got %0d want 0", op, b, tr_post); end
    end
  endtask

  initial begin
    test_reset;
    test_rtype_nowait;
    test_load_stall;
    test_store;
    test_branch;
    test_ext_jal;
    test_reset_mid_mem;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
